// File: rtl/wr_flag_ctrl.sv
// Write-side pointer and flag controller for the asynchronous FIFO.
// Define WR_FLAG_CTRL_AF_HYST_EN to give almost_full_flag a release hysteresis of AF_HYST words.
module wr_flag_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_HYST     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W:0]   read_gray_pointer,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic              ovf_clear,
    output logic [ADDR_W-1:0] write_addr,
    output logic [ADDR_W:0]   write_binary_pointer,
    output logic [ADDR_W:0]   write_gray_pointer,
    output logic              ram_we,
    output logic [ADDR_W:0]   fill_level,
    output logic              full_flag,
    output logic              almost_full_flag,
    output logic              overflow_flag
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("wr_flag_ctrl: SYNC_STAGES must be in 2..4");
        end
        if (AF_HYST < 0 || AF_HYST >= DEPTH) begin : g_bad_hyst
            $error("wr_flag_ctrl: AF_HYST must be below DEPTH");
        end
    endgenerate

    function automatic logic [ADDR_W:0] gray_to_bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b = g;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] wptr_bin;
    logic [ADDR_W:0] wptr_gray;
    logic [ADDR_W:0] rgray_sync [SYNC_STAGES];
    logic [ADDR_W:0] rptr_bin_sync;
    logic [ADDR_W:0] next_wptr;
    logic [ADDR_W:0] next_gray;
    logic [ADDR_W:0] next_level;
    logic            accept;
    logic            almost_full_next;

    assign accept        = write_en & ~full_flag;
    assign rptr_bin_sync = gray_to_bin(rgray_sync[SYNC_STAGES-1]);
    assign next_wptr     = wptr_bin + {{ADDR_W{1'b0}}, accept};
    assign next_gray     = next_wptr ^ (next_wptr >> 1);
    // Modular subtraction keeps the level correct across the pointer wrap.
    assign next_level    = next_wptr - rptr_bin_sync;

`ifdef WR_FLAG_CTRL_AF_HYST_EN
    localparam logic [ADDR_W:0] HYST = (ADDR_W+1)'(AF_HYST);
    logic [ADDR_W:0] af_release;

    always_comb begin
        af_release       = (af_thresh > HYST) ? (af_thresh - HYST) : '0;
        almost_full_next = almost_full_flag;
        if (next_level >= af_thresh) begin
            almost_full_next = 1'b1;
        end else if (next_level < af_release) begin
            almost_full_next = 1'b0;
        end
    end
`else
    always_comb begin
        almost_full_next = (next_level >= af_thresh);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rgray_sync[i] <= '0;
            end
        end else begin
            rgray_sync[0] <= read_gray_pointer;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rgray_sync[i] <= rgray_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_bin         <= '0;
            wptr_gray        <= '0;
            fill_level       <= '0;
            full_flag        <= 1'b0;
            almost_full_flag <= 1'b0;
        end else begin
            wptr_bin         <= next_wptr;
            wptr_gray        <= next_gray;
            fill_level       <= next_level;
            full_flag        <= (next_level == FULL_LEVEL);
            almost_full_flag <= almost_full_next;
        end
    end

    // A rejected write in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_flag <= 1'b0;
        end else if (write_en && full_flag) begin
            overflow_flag <= 1'b1;
        end else if (ovf_clear) begin
            overflow_flag <= 1'b0;
        end
    end

    assign ram_we               = accept;
    assign write_addr           = wptr_bin[ADDR_W-1:0];
    assign write_binary_pointer = wptr_bin;
    assign write_gray_pointer   = wptr_gray;

endmodule

// File: tb/tb_wr_flag_ctrl.sv
// Directed vector bench for wr_flag_ctrl (ADDR_W=4, SYNC_STAGES=2, AF_HYST=2).
// Expected almost-full values follow WR_FLAG_CTRL_AF_HYST_EN when it is defined.
module tb_wr_flag_ctrl;

`ifdef WR_FLAG_CTRL_AF_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       write_en;
    logic [4:0] read_gray_pointer;
    logic [4:0] af_thresh;
    logic       ovf_clear;
    logic [3:0] write_addr;
    logic [4:0] write_binary_pointer;
    logic [4:0] write_gray_pointer;
    logic       ram_we;
    logic [4:0] fill_level;
    logic       full_flag;
    logic       almost_full_flag;
    logic       overflow_flag;

    wr_flag_ctrl #(.ADDR_W(4), .SYNC_STAGES(2), .AF_HYST(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .write_en             (write_en),
        .read_gray_pointer    (read_gray_pointer),
        .af_thresh            (af_thresh),
        .ovf_clear            (ovf_clear),
        .write_addr           (write_addr),
        .write_binary_pointer (write_binary_pointer),
        .write_gray_pointer   (write_gray_pointer),
        .ram_we               (ram_we),
        .fill_level           (fill_level),
        .full_flag            (full_flag),
        .almost_full_flag     (almost_full_flag),
        .overflow_flag        (overflow_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic       clr;
        logic [4:0] thr;
        logic [4:0] rg;
        logic       x_we;
        logic [3:0] x_addr;
        logic [4:0] x_fill;
        logic       x_full;
        logic       x_af;
        logic       x_ovf;
        logic [4:0] x_wptr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [4:0] gray(input int k);
        logic [4:0] b;
        b = 5'(k);
        return b ^ (b >> 1);
    endfunction

    // af_d: expected flag without hysteresis, af_h: with hysteresis
    task automatic add(input int r, we, clr, thr, rgk, x_we, x_addr, x_fill,
                       x_full, af_d, af_h, x_ovf, x_wptr);
        vec_t v;
        v.rst    = 1'(r);
        v.we     = 1'(we);
        v.clr    = 1'(clr);
        v.thr    = 5'(thr);
        v.rg     = gray(rgk);
        v.x_we   = 1'(x_we);
        v.x_addr = 4'(x_addr);
        v.x_fill = 5'(x_fill);
        v.x_full = 1'(x_full);
        v.x_af   = HYST_ON ? 1'(af_h) : 1'(af_d);
        v.x_ovf  = 1'(x_ovf);
        v.x_wptr = 5'(x_wptr);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [4:0] xg;
        rst               = v.rst;
        write_en          = v.we;
        ovf_clear         = v.clr;
        af_thresh         = v.thr;
        read_gray_pointer = v.rg;
        #1;
        chk("ram_we", idx, 32'(ram_we), 32'(v.x_we));
        chk("write_addr", idx, 32'(write_addr), 32'(v.x_addr));
        @(posedge clk);
        #1;
        xg = v.x_wptr ^ (v.x_wptr >> 1);
        chk("fill_level", idx, 32'(fill_level), 32'(v.x_fill));
        chk("full_flag", idx, 32'(full_flag), 32'(v.x_full));
        chk("almost_full_flag", idx, 32'(almost_full_flag), 32'(v.x_af));
        chk("overflow_flag", idx, 32'(overflow_flag), 32'(v.x_ovf));
        chk("write_binary_pointer", idx, 32'(write_binary_pointer), 32'(v.x_wptr));
        chk("write_gray_pointer", idx, 32'(write_gray_pointer), 32'(xg));
    endtask

    initial begin
        // reset: first edge outside the table, then two checked reset cycles
        add(1, 0, 0, 14, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 14, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        // fill to full, read pointer at 0
        for (int k = 0; k < 16; k++)
            add(0, 1, 0, 14, 0,  1, k, k + 1, int'(k == 15), int'(k >= 13), int'(k >= 13), 0, k + 1);
        // overflow, clear, set-wins, clear
        add(0, 1, 0, 14, 0,  0, 0, 16, 1, 1, 1, 1, 16);
        add(0, 0, 0, 14, 0,  0, 0, 16, 1, 1, 1, 1, 16);
        add(0, 0, 1, 14, 0,  0, 0, 16, 1, 1, 1, 0, 16);
        add(0, 1, 1, 14, 0,  0, 0, 16, 1, 1, 1, 1, 16);
        add(0, 0, 1, 14, 0,  0, 0, 16, 1, 1, 1, 0, 16);
        // read pointer to 4: visible on the third edge
        add(0, 0, 0, 14, 4,  0, 0, 16, 1, 1, 1, 0, 16);
        add(0, 0, 0, 14, 4,  0, 0, 16, 1, 1, 1, 0, 16);
        add(0, 0, 0, 14, 4,  0, 0, 12, 0, 0, 1, 0, 16);
        // 20 writes with read stepping; write pointer wraps 31 -> 0
        for (int j = 0; j < 20; j++)
            add(0, 1, 0, 14, 5 + j,  1, j % 16, (j == 0) ? 13 : 14, 0, int'(j > 0), 1, 0, (17 + j) % 32);
        add(0, 0, 0, 14, 24,  0, 4, 13, 0, 0, 1, 0, 4);
        add(0, 0, 0, 14, 24,  0, 4, 12, 0, 0, 1, 0, 4);
        add(0, 0, 0, 14, 24,  0, 4, 12, 0, 0, 1, 0, 4);
        // climb to 15, then write as a read update lands
        add(0, 1, 0, 14, 24,  1, 4, 13, 0, 0, 1, 0, 5);
        add(0, 1, 0, 14, 24,  1, 5, 14, 0, 1, 1, 0, 6);
        add(0, 1, 0, 14, 25,  1, 6, 15, 0, 1, 1, 0, 7);
        add(0, 0, 0, 14, 25,  0, 7, 15, 0, 1, 1, 0, 7);
        add(0, 1, 0, 14, 25,  1, 7, 15, 0, 1, 1, 0, 8);
        add(0, 1, 0, 14, 25,  1, 8, 16, 1, 1, 1, 0, 9);
        add(0, 1, 0, 14, 25,  0, 9, 16, 1, 1, 1, 1, 9);
        // mid-stream reset while full: rejected write, everything cleared
        add(1, 1, 0, 14, 0,  0, 9, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 14, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // threshold extremes at level 0
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 17, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        // hysteresis: fill to 14, then drain one word per cycle
        for (int k = 0; k < 14; k++)
            add(0, 1, 0, 14, 0,  1, k, k + 1, 0, int'(k == 13), int'(k == 13), 0, k + 1);
        add(0, 0, 0, 14, 1,  0, 14, 14, 0, 1, 1, 0, 14);
        add(0, 0, 0, 14, 2,  0, 14, 14, 0, 1, 1, 0, 14);
        add(0, 0, 0, 14, 3,  0, 14, 13, 0, 0, 1, 0, 14);
        add(0, 0, 0, 14, 3,  0, 14, 12, 0, 0, 1, 0, 14);
        add(0, 0, 0, 14, 3,  0, 14, 11, 0, 0, 0, 0, 14);
        add(0, 0, 0, 14, 3,  0, 14, 11, 0, 0, 0, 0, 14);

        rst               = 1'b1;
        write_en          = 1'b0;
        ovf_clear         = 1'b0;
        af_thresh         = 5'd14;
        read_gray_pointer = 5'd0;
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(i, vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
